// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses, flushes on redirect.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module ifetch_queue #(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned DEPTH             = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imemReqValid,
    input  logic                         imemReqReady,
    output logic [ADDR_WIDTH-1:0]        imemReqAddr,
    input  logic                         imemRspValid,
    input  logic [INSTRUCTION_WIDTH-1:0] imemRspData,
    input  logic                         redirectValid,
    input  logic [ADDR_WIDTH-1:0]        redirectPc,
    output logic                         instrValid,
    input  logic                         instrReady,
    output logic [INSTRUCTION_WIDTH-1:0] instrOut,
    output logic [ADDR_WIDTH-1:0]        pcOut
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_WIDTH-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]        rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]                count_q, count_d;
    logic [CW-1:0]                inflight_q, inflight_d;
    logic [CW-1:0]                discard_q, discard_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [INSTRUCTION_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]        pc_mem   [DEPTH];

    logic has_head, rsp_ok, bypass, req_fire, pop, push;

    // Handshakes and output muxing; rsp_pc_q is the PC of the next response that will be kept
    always_comb begin
        has_head = (count_q != '0);
        rsp_ok   = imemRspValid && (inflight_q != '0);
`ifdef IFQ_BYPASS_EN
        bypass   = !has_head && (discard_q == '0) && !redirectValid && rsp_ok;
`else
        bypass   = 1'b0;
`endif
        imemReqValid = !rst && !redirectValid &&
                       (((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
        imemReqAddr  = fetch_pc_q;
        req_fire     = imemReqValid && imemReqReady;
        instrValid   = has_head || bypass;
        instrOut     = '0;
        pcOut        = '0;
        if (has_head) begin
            instrOut = data_mem[rd_ptr_q];
            pcOut    = pc_mem[rd_ptr_q];
        end else if (bypass) begin
            instrOut = imemRspData;
            pcOut    = rsp_pc_q;
        end
        pop  = has_head && instrReady && !redirectValid;
        push = rsp_ok && (discard_q == '0) && !redirectValid && !(bypass && instrReady);
    end

    // Next-state computation
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirectValid) begin
            fetch_pc_d = redirectPc;
            rsp_pc_d   = redirectPc;
            count_d    = '0;
            discard_d  = inflight_q - CW'(rsp_ok);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
            if (rsp_ok && (discard_q == '0)) rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(4);
            count_d = count_q + CW'(push) - CW'(pop);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage; contents are only observable through count_q so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imemRspData;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, corner-case sequences and random traffic vs a queue-based model.
module tb_ifetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst, imemReqValid, imemReqReady, imemRspValid, redirectValid;
    logic        instrValid, instrReady;
    logic [31:0] imemReqAddr, imemRspData, redirectPc, instrOut, pcOut;

    always #5 clk = ~clk;

    ifetch_queue #(.ADDR_WIDTH(32), .INSTRUCTION_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .instrValid(instrValid), .instrReady(instrReady), .instrOut(instrOut), .pcOut(pcOut)
    );

    typedef struct packed { logic [31:0] data; logic [31:0] pc; } ent_t;

    // Reference model: queued words, PCs of outstanding requests, words still to drop
    ent_t        mq[$];
    logic [31:0] minfl[$];
    int          mdisc;
    logic [31:0] mfetch;
    logic [31:0] mem_pend[$];

    int          checks = 0, errors = 0;
    logic        obs_rv, obs_iv, obs_hs;
    logic [31:0] obs_addr, obs_io, obs_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    task automatic step(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                        input logic rdv, input logic [31:0] rpc, input logic ir);
        logic        byp, e_rv, e_iv, hs, rok;
        logic [31:0] e_io, e_pc, e_addr, pc;
        int          nq, ni;
        ent_t        e;
        rst = r; imemReqReady = rr; imemRspValid = rv; imemRspData = rd;
        redirectValid = rdv; redirectPc = rpc; instrReady = ir;
        @(negedge clk);
        nq = mq.size();
        ni = minfl.size();
`ifdef IFQ_BYPASS_EN
        byp = !r && nq == 0 && mdisc == 0 && !rdv && rv && ni > 0;
`else
        byp = 1'b0;
`endif
        e_rv   = !r && !rdv && (nq + ni < int'(DEPTH));
        e_iv   = !r && (nq > 0 || byp);
        e_addr = r ? RESET_PC : mfetch;
        e_io   = '0;
        e_pc   = '0;
        if (!r && nq > 0) begin
            e_io = mq[0].data; e_pc = mq[0].pc;
        end else if (byp) begin
            e_io = rd; e_pc = minfl[0];
        end
        chk("req_valid", 32'(imemReqValid), 32'(e_rv));
        chk("req_addr", imemReqAddr, e_addr);
        chk("instr_valid", 32'(instrValid), 32'(e_iv));
        if (e_iv || r) begin
            chk("instr_out", instrOut, e_io);
            chk("pc_out", pcOut, e_pc);
        end
        obs_rv = imemReqValid; obs_iv = instrValid; obs_addr = imemReqAddr;
        obs_io = instrOut; obs_pc = pcOut;
        hs = e_rv && rr;
        obs_hs = hs;
        @(posedge clk);
        if (rv && mem_pend.size() > 0) void'(mem_pend.pop_front());
        if (hs) mem_pend.push_back(mfetch);
        if (r) begin
            mq.delete(); minfl.delete(); mdisc = 0; mfetch = RESET_PC;
        end else begin
            rok = rv && ni > 0;
            if (rdv) begin
                if (rok) void'(minfl.pop_front());
                mdisc  = minfl.size();
                mq.delete();
                mfetch = rpc;
            end else begin
                if (nq > 0 && ir) void'(mq.pop_front());
                if (rok) begin
                    pc = minfl.pop_front();
                    if (mdisc > 0) mdisc--;
                    else if (!(byp && ir)) begin
                        e.data = rd; e.pc = pc;
                        mq.push_back(e);
                    end
                end
                if (hs) begin
                    minfl.push_back(mfetch);
                    mfetch = mfetch + 32'd4;
                end
            end
        end
        #1;
    endtask

    // One cycle with the bench memory answering the oldest pending request
    task automatic mstep(input logic rr, input logic rsp_en, input logic rdv,
                         input logic [31:0] rpc, input logic ir);
        logic        rv;
        logic [31:0] d;
        if (mem_pend.size() > 0) begin
            rv = rsp_en; d = mem_word(mem_pend[0]);
        end else begin
            rv = ($urandom_range(7) == 0); d = $urandom();
        end
        step(1'b0, rr, rv, d, rdv, rpc, ir);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        mem_pend.delete();
    endtask

    typedef struct {
        logic r, rr, rv; logic [31:0] rd; logic rdv; logic [31:0] rpc; logic ir;
        logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_io, e_pc;
    } vec_t;

    vec_t tbl[10];
    int   nhs;
    logic found;

    initial begin
        mfetch = RESET_PC; mdisc = 0;
        rst = 1'b1; imemReqReady = 1'b0; imemRspValid = 1'b0; imemRspData = '0;
        redirectValid = 1'b0; redirectPc = '0; instrReady = 1'b0;

        tbl[0] = '{1,0,0,32'h0,0,32'h0,0,  0,32'h0,  0,32'h0,0};
        tbl[1] = '{0,1,0,32'h0,0,32'h0,1,  1,32'h0,  0,32'h0,0};
`ifdef IFQ_BYPASS_EN
        tbl[2] = '{0,1,1,32'h00500093,0,32'h0,1, 1,32'h4, 1,32'h00500093,32'h0};
        tbl[3] = '{0,1,1,32'h11,0,32'h0,1,       1,32'h8, 1,32'h11,32'h4};
        tbl[4] = '{0,1,1,32'h22,0,32'h0,0,       1,32'hC, 1,32'h22,32'h8};
        tbl[5] = '{0,1,1,32'h33,1,32'h100,1,     0,32'h10,1,32'h22,32'h8};
        tbl[7] = '{0,0,1,32'h44,0,32'h0,1,       1,32'h104,1,32'h44,32'h100};
        tbl[8] = '{0,0,0,32'h0,0,32'h0,1,        1,32'h104,0,32'h0,32'h0};
`else
        tbl[2] = '{0,1,1,32'h00500093,0,32'h0,1, 1,32'h4, 0,32'h0,32'h0};
        tbl[3] = '{0,1,1,32'h11,0,32'h0,1,       1,32'h8, 1,32'h00500093,32'h0};
        tbl[4] = '{0,1,1,32'h22,0,32'h0,0,       1,32'hC, 1,32'h11,32'h4};
        tbl[5] = '{0,1,1,32'h33,1,32'h100,1,     0,32'h10,1,32'h11,32'h4};
        tbl[7] = '{0,0,1,32'h44,0,32'h0,1,       1,32'h104,0,32'h0,32'h0};
        tbl[8] = '{0,0,0,32'h0,0,32'h0,1,        1,32'h104,1,32'h44,32'h100};
`endif
        tbl[6] = '{0,1,0,32'h0,0,32'h0,1,  1,32'h100,0,32'h0,32'h0};
        tbl[9] = '{0,0,0,32'h0,0,32'h0,1,  1,32'h104,0,32'h0,32'h0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].rdv, tbl[i].rpc, tbl[i].ir);
            chk($sformatf("tbl%0d_req_valid", i), 32'(obs_rv), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_req_addr", i), obs_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_instr_valid", i), 32'(obs_iv), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d_instr_out", i), obs_io, tbl[i].e_io);
                chk($sformatf("tbl%0d_pc_out", i), obs_pc, tbl[i].e_pc);
            end
        end

        // Decode stalled: fetch must stop once queue plus outstanding reach DEPTH
        do_reset();
        nhs = 0;
        for (int i = 0; i < 10; i++) begin
            mstep(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (obs_hs) nhs++;
        end
        chk("stall_handshakes", 32'(nhs), 32'd4);
        chk("stall_req_valid", 32'(obs_rv), 32'd0);
        chk("stall_instr_valid", 32'(obs_iv), 32'd1);
        for (int i = 0; i < 10; i++) mstep(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect with two responses outstanding
        do_reset();
        mstep(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        mstep(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        mstep(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
        chk("redirect_no_request", 32'(obs_rv), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            mstep(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            found = obs_iv;
        end
        chk("redirect_instr_seen", 32'(found), 32'd1);
        chk("redirect_first_pc", obs_pc, 32'h100);

        // Reset mid-stream with three requests outstanding, then a late response
        do_reset();
        for (int i = 0; i < 3; i++) mstep(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        chk("reset_restart_addr", obs_addr, RESET_PC);
        chk("reset_late_rsp_ignored", 32'(obs_iv), 32'd0);
        mem_pend.delete();
        for (int i = 0; i < 8; i++) mstep(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Random traffic, redirects (including near address wrap) and occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) do_reset();
            else mstep($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(39) == 0,
                       ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC),
                       $urandom_range(2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the PC/fetch address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, meaning the fetched word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-007 SHALL have port imemReqValid, output, 1, meaning fetch request valid.
REQ-008 SHALL have port imemReqReady, input, 1, meaning instruction memory accepts the request.
REQ-009 SHALL have port imemReqAddr, output, ADDR_WIDTH, meaning the fetch address.
REQ-010 SHALL have port imemRspValid, input, 1, meaning a returned word is present (in order).
REQ-011 SHALL have port imemRspData, input, INSTRUCTION_WIDTH, meaning the returned word.
REQ-012 SHALL have port redirectValid, input, 1, meaning a taken branch/jump flush.
REQ-013 SHALL have port redirectPc, input, ADDR_WIDTH, meaning the new fetch address.
REQ-014 SHALL have port instrValid, output, 1, meaning queue head valid toward IF/ID.
REQ-015 SHALL have port instrReady, input, 1, meaning decode consumes head (low = hazard stall).
REQ-016 SHALL have ports instrOut (INSTRUCTION_WIDTH) and pcOut (ADDR_WIDTH), outputs, meaning the head word and its PC.

Function
REQ-017 SHALL hold fetchPc, queue count (0..DEPTH), inflight counter (0..DEPTH) and discard counter (0..DEPTH).
REQ-018 SHALL drive imemReqValid = (count + inflight < DEPTH) and not redirectValid; imemReqAddr = fetchPc.
REQ-019 SHALL, on request handshake (imemReqValid and imemReqReady), increment inflight and advance fetchPc by 4, wrapping modulo 2^ADDR_WIDTH.
REQ-020 SHALL, on imemRspValid with discard = 0, push {imemRspData, PC of that request} into the queue and decrement inflight.
REQ-021 SHALL, on imemRspValid with discard > 0, drop the word and decrement both discard and inflight.
REQ-022 SHALL pop the head when instrValid and instrReady; instrValid = (count > 0).
REQ-023 SHALL support simultaneous push and pop in one cycle with count unchanged; full queue with pop and push SHALL lose nothing.
REQ-024 SHALL, on redirectValid, in that cycle: empty the queue (count = 0), set fetchPc = redirectPc, set discard = inflight minus any response dropped that cycle, issue no request; a concurrent pop or response SHALL be discarded.
REQ-025 SHALL treat imemRspValid with inflight = 0 as protocol error: ignore it, no state change.
REQ-026 SHALL give minimum latency from request acceptance to instrValid of one cycle after response (registered queue), except as in REQ-031.
REQ-027 SHALL keep instrOut/pcOut stable while instrValid and not instrReady.

Reset
REQ-028 SHALL, while rst is high, force: fetchPc = RESET_PC, count = 0, inflight = 0, discard = 0, imemReqValid = 0, instrValid = 0, instrOut = 0, pcOut = 0.
REQ-029 SHALL issue the first request at RESET_PC in the first cycle after rst deasserts; responses to requests issued before a mid-operation reset SHALL be ignored after reset (inflight = 0).

Configuration
REQ-030 SHALL use macro IFQ_BYPASS_EN.
REQ-031 SHALL, with IFQ_BYPASS_EN defined, when count = 0, discard = 0, no redirect and imemRspValid, present the response combinationally on instrOut/pcOut with instrValid = 1; if instrReady it SHALL not be written to the queue.
REQ-032 SHALL, without IFQ_BYPASS_EN, always write responses to the queue first (instrValid earliest next cycle).

Verification
REQ-033 Reset release, imemReqReady = 1, 1-cycle-latency memory, instrReady = 1 -> requests 0x0,0x4,0x8...; pcOut sequence 0x0,0x4,0x8 with matching words.
REQ-034 instrReady = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests accepted, count = 4, imemReqValid = 0; release -> 4 pops in order, fetching resumes.
REQ-035 Redirect to 0x100 with 2 responses inflight -> those 2 responses dropped, queue empty, next request address 0x100, next pcOut 0x100.
REQ-036 Redirect in same cycle as pop and response -> neither popped word nor response appears; no request issued that cycle.
REQ-037 rst asserted mid-stream with 3 inflight -> outputs zero immediately; late responses ignored; fetch restarts at RESET_PC.
REQ-038 With IFQ_BYPASS_EN, empty queue, response 0x00500093 at PC 0x0 -> instrValid = 1 and instrOut = 0x00500093 in the same cycle; without macro -> next cycle.
